hazard_stall_ctrl: RTL

Parametrised hazard detection and stall/flush sequencer for the 5-stage pipeline, sitting beside the ID stage. It replaces the purely combinational load-use/branch stall logic with a counter-driven FSM that holds PC and IF/ID for a configurable number of cycles per hazard class. It injects an ID/EX bubble, flushes IF/ID on taken branches and accepts an external flush that overrides any stall. Register 0 never creates a hazard.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl_stall_timer.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard stall/flush sequencer.
// Exports the FSM state enum, the hazard cause enum and the idle output values.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LOAD_USE = 2'd1,
        BR_ALU   = 2'd2,
        BR_LOAD  = 2'd3
    } cause_e;

    localparam logic IDLE_PC_WRITE    = 1'b1;
    localparam logic IDLE_IFID_WRITE  = 1'b1;
    localparam logic IDLE_IFID_FLUSH  = 1'b0;
    localparam logic IDLE_IDEX_BUBBLE = 1'b0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID stage and the hazard sequencer.
// master: pipeline drives ID/EX info and reads controls; slave: sequencer.
interface hazard_stall_ctrl_if #(
    parameter int RA_W = 5
);
    logic            stall_en;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_branch;
    logic            id_br_taken;
    logic [RA_W-1:0] ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ext_flush;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            stall_busy;
    logic [1:0]      stall_cause;

    modport master (
        output stall_en, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_branch, id_br_taken, ex_rd, ex_regwrite,
        output ex_memread, ext_flush,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
        input  stall_busy, stall_cause
    );

    modport slave (
        input  stall_en, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_branch, id_br_taken, ex_rd, ex_regwrite,
        input  ex_memread, ext_flush,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
        output stall_busy, stall_cause
    );

endinterface

// File: rtl/hazard_stall_ctrl_stall_timer.sv
// Loadable down-counter holding the remaining STALL cycles.
// Ports: load/value preset, clr to zero, dec steps down, zero flags empty.
module stall_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             clr,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load)
            cnt_d = value;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall/flush sequencer beside the ID stage.
// Ports: clk, rst_n, hz (slave bundle); perf_* when HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W         = 5,
    parameter int LOAD_USE_CYC = 1,
    parameter int BR_ALU_CYC   = 1,
    parameter int BR_LOAD_CYC  = 2,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cyc,
    output logic [31:0]         perf_flush_cnt
`endif
);

    // Counter preset is CYC-2: cycle 1 is the RUN cycle itself.
    localparam logic [CNT_W-1:0] LU_V =
        CNT_W'(LOAD_USE_CYC > 1 ? LOAD_USE_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] BA_V =
        CNT_W'(BR_ALU_CYC > 1 ? BR_ALU_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] BL_V =
        CNT_W'(BR_LOAD_CYC > 1 ? BR_LOAD_CYC - 2 : 0);

    state_e state_q, state_d;
    cause_e cause_q, cause_d;
    cause_e det;

    logic             mt_rs, mt_rt, m;
    logic             multi;
    logic [CNT_W-1:0] pre_v;
    logic             t_load, t_clr, t_dec, t_zero;

    logic       pc_write, ifid_write, ifid_flush;
    logic       idex_bubble, stall_busy;
    logic [1:0] stall_cause;

    always_comb begin
        mt_rs = hz.id_use_rs && (hz.id_rs == hz.ex_rd)
              && (hz.ex_rd != RA_W'(0));
        mt_rt = hz.id_use_rt && (hz.id_rt == hz.ex_rd)
              && (hz.ex_rd != RA_W'(0));
        m = mt_rs | mt_rt;

        det = NONE;
        if (hz.id_branch && hz.ex_memread && m)
            det = BR_LOAD;
        else if (hz.id_branch && hz.ex_regwrite && m)
            det = BR_ALU;
        else if (!hz.id_branch && hz.ex_memread && m)
            det = LOAD_USE;

        multi = 1'b0;
        pre_v = '0;
        unique case (det)
            LOAD_USE: begin
                multi = (LOAD_USE_CYC > 1);
                pre_v = LU_V;
            end
            BR_ALU: begin
                multi = (BR_ALU_CYC > 1);
                pre_v = BA_V;
            end
            BR_LOAD: begin
                multi = (BR_LOAD_CYC > 1);
                pre_v = BL_V;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_write    = IDLE_PC_WRITE;
        ifid_write  = IDLE_IFID_WRITE;
        ifid_flush  = IDLE_IFID_FLUSH;
        idex_bubble = IDLE_IDEX_BUBBLE;
        stall_busy  = 1'b0;
        stall_cause = NONE;
        state_d     = state_q;
        cause_d     = cause_q;
        t_load      = 1'b0;
        t_clr       = 1'b0;
        t_dec       = 1'b0;

        if (!rst_n) begin
            // Outputs held idle while reset is asserted.
        end else if (hz.ext_flush) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
            cause_d     = NONE;
            t_clr       = 1'b1;
        end else if (!hz.stall_en) begin
            state_d = RUN;
            cause_d = NONE;
            t_clr   = 1'b1;
        end else if (state_q == STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_busy  = 1'b1;
            stall_cause = cause_q;
            if (t_zero) begin
                state_d = RUN;
                cause_d = NONE;
            end else begin
                t_dec = 1'b1;
            end
        end else if (det != NONE) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_cause = det;
            if (multi) begin
                state_d = STALL;
                cause_d = det;
                t_load  = 1'b1;
            end
        end else if (hz.id_branch && hz.id_br_taken) begin
            ifid_flush = 1'b1;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cause_q <= NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    stall_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (t_load),
        .value (pre_v),
        .clr   (t_clr),
        .dec   (t_dec),
        .zero  (t_zero)
    );

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.stall_busy  = stall_busy;
    assign hz.stall_cause = stall_cause;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Both counters saturate instead of wrapping.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (!pc_write && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + 32'd1;
        if (ifid_flush && perf_flush_q != '1)
            perf_flush_d = perf_flush_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
